// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO calendar array: cell update-select codes and rank extraction.
package pifo_pkg;

  localparam logic [1:0] SEL_SELF  = 2'd0;
  localparam logic [1:0] SEL_INPUT = 2'd1;
  localparam logic [1:0] SEL_TAIL  = 2'd2;
  localparam logic [1:0] SEL_HEAD  = 2'd3;

  localparam int MAX_ELEM_W = 256;
  localparam int MAX_RANK_W = 64;

  // Callers zero-extend the element to MAX_ELEM_W and truncate the result to their rank width.
  function automatic logic [MAX_RANK_W-1:0] rank_of(input logic [MAX_ELEM_W-1:0] elem,
                                                    input int unsigned pos,
                                                    input int unsigned width);
    logic [MAX_RANK_W-1:0] mask;
    mask = (width >= MAX_RANK_W) ? '1 : ((64'd1 << width) - 64'd1);
    return MAX_RANK_W'(elem >> pos) & mask;
  endfunction

endpackage

// File: rtl/pifo_calendar_cell.sv
// One PIFO calendar cell: element register plus valid bit, 4:1 next-value mux and rank comparator.
module pifo_calendar_cell
  import pifo_pkg::*;
#(
  parameter int ELEMENT_WIDTH  = 32,
  parameter int RANK_WIDTH     = 19,
  parameter int RANK_START_POS = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [1:0]               sel,
  input  logic [ELEMENT_WIDTH-1:0] push_data,
  input  logic [RANK_WIDTH-1:0]    push_rank,
  input  logic [ELEMENT_WIDTH-1:0] prev_data,
  input  logic                     prev_valid,
  input  logic [ELEMENT_WIDTH-1:0] next_data,
  input  logic                     next_valid,
  output logic [ELEMENT_WIDTH-1:0] data,
  output logic                     valid,
  output logic                     larger
);

  logic [RANK_WIDTH-1:0] rank;

  assign rank   = RANK_WIDTH'(rank_of(MAX_ELEM_W'(data), RANK_START_POS, RANK_WIDTH));
  // Strict compare keeps equal ranks in arrival order.
  assign larger = ~valid | (push_rank < rank);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      case (sel)
        SEL_INPUT: begin
          data  <= push_data;
          valid <= 1'b1;
        end
        SEL_TAIL: begin
          data  <= prev_data;
          valid <= prev_valid;
        end
        SEL_HEAD: begin
          data  <= next_data;
          valid <= next_valid;
        end
        default: begin
          data  <= data;
          valid <= valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/pifo_calendar_array_v0_3.sv
// PIFO calendar queue of DEPTH rank-sorted cells (head at cell 0) with push/pop handshakes.
// Optional macro PIFO_TAIL_EVICT_EN: a lower-rank push into a full queue evicts the tail element.
module pifo_calendar_array_v0_3
  import pifo_pkg::*;
#(
  parameter  int ELEMENT_WIDTH  = 32,
  parameter  int RANK_WIDTH     = 19,
  parameter  int RANK_START_POS = 12,
  parameter  int DEPTH          = 16,
  localparam int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_push_valid,
  output logic                     s_push_ready,
  input  logic [ELEMENT_WIDTH-1:0] s_push_data,
  output logic                     m_pop_valid,
  input  logic                     m_pop_ready,
  output logic [ELEMENT_WIDTH-1:0] m_pop_data,
`ifdef PIFO_TAIL_EVICT_EN
  output logic                     m_evict_valid,
  output logic [ELEMENT_WIDTH-1:0] m_evict_data,
`endif
  output logic [CNT_WIDTH-1:0]     out_count,
  output logic                     out_full,
  output logic                     out_empty
);

  logic [ELEMENT_WIDTH-1:0] cell_data [DEPTH];
  logic [DEPTH-1:0]         cell_valid;
  logic [DEPTH-1:0]         cell_larger;
  logic [1:0]               cell_sel [DEPTH];
  logic [CNT_WIDTH-1:0]     count;
  logic [CNT_WIDTH-1:0]     ins;
  logic [CNT_WIDTH-1:0]     slot;
  logic [RANK_WIDTH-1:0]    push_rank;
  logic                     push_fire;
  logic                     pop_fire;

  assign push_rank   = RANK_WIDTH'(rank_of(MAX_ELEM_W'(s_push_data), RANK_START_POS, RANK_WIDTH));
  assign out_count   = count;
  assign out_full    = (count == CNT_WIDTH'(DEPTH));
  assign out_empty   = (count == '0);
  assign m_pop_valid = ~out_empty;
  assign m_pop_data  = cell_data[0];
`ifdef PIFO_TAIL_EVICT_EN
  // When full, the tail's larger flag is exactly "push rank below tail rank".
  assign s_push_ready = ~out_full | m_pop_ready | cell_larger[DEPTH-1];
`else
  assign s_push_ready = ~out_full | m_pop_ready;
`endif
  assign push_fire = s_push_valid & s_push_ready;
  assign pop_fire  = m_pop_valid & m_pop_ready;

  // Larger flags are monotonic along the sorted array; the first set one is the insert point.
  always_comb begin
    ins = CNT_WIDTH'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cell_larger[i]) ins = CNT_WIDTH'(i);
    end
    slot = (ins == '0) ? '0 : ins - CNT_WIDTH'(1);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_sel[i] = SEL_SELF;
      if (push_fire && !pop_fire) begin
        if (CNT_WIDTH'(i) == ins)     cell_sel[i] = SEL_INPUT;
        else if (CNT_WIDTH'(i) > ins) cell_sel[i] = SEL_TAIL;
      end else if (pop_fire && !push_fire) begin
        cell_sel[i] = SEL_HEAD;
      end else if (push_fire && pop_fire) begin
        if (CNT_WIDTH'(i) < slot)       cell_sel[i] = SEL_HEAD;
        else if (CNT_WIDTH'(i) == slot) cell_sel[i] = SEL_INPUT;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [ELEMENT_WIDTH-1:0] prev_d;
    logic [ELEMENT_WIDTH-1:0] next_d;
    logic                     prev_v;
    logic                     next_v;

    if (g == 0) begin : g_first
      assign prev_d = '0;
      assign prev_v = 1'b0;
    end else begin : g_prev
      assign prev_d = cell_data[g-1];
      assign prev_v = cell_valid[g-1];
    end

    if (g == DEPTH - 1) begin : g_last
      assign next_d = '0;
      assign next_v = 1'b0;
    end else begin : g_next
      assign next_d = cell_data[g+1];
      assign next_v = cell_valid[g+1];
    end

    pifo_calendar_cell #(
      .ELEMENT_WIDTH  (ELEMENT_WIDTH),
      .RANK_WIDTH     (RANK_WIDTH),
      .RANK_START_POS (RANK_START_POS)
    ) u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .sel        (cell_sel[g]),
      .push_data  (s_push_data),
      .push_rank  (push_rank),
      .prev_data  (prev_d),
      .prev_valid (prev_v),
      .next_data  (next_d),
      .next_valid (next_v),
      .data       (cell_data[g]),
      .valid      (cell_valid[g]),
      .larger     (cell_larger[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (push_fire && !pop_fire && !out_full) begin
      count <= count + CNT_WIDTH'(1);
    end else if (pop_fire && !push_fire) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

`ifdef PIFO_TAIL_EVICT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_evict_valid <= 1'b0;
      m_evict_data  <= '0;
    end else begin
      m_evict_valid <= push_fire & ~pop_fire & out_full;
      if (push_fire && !pop_fire && out_full) m_evict_data <= cell_data[DEPTH-1];
    end
  end
`endif

endmodule
